// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the radix-2 Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // {LQ[0], Q_1} patterns that call for an add or subtract of M
    localparam logic [1:0] ADD_M = 2'b01;
    localparam logic [1:0] SUB_M = 2'b10;

endpackage

`default_nettype wire

// File: rtl/booth_datapath.sv
// ============================================================================
// Module      : booth_datapath
// Description : Booth accumulator datapath: M, HQ, LQ, Q_1 and add/subtract.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_datapath
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load_a,
    input  logic               i_load_b,
    input  logic               i_load_add,
    input  logic               i_add_sub,
    input  logic               i_shift_hq_lq_q_1,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [1:0]         o_q_lsb,
    output logic [2*WIDTH-1:0] o_product_next
);

    logic [WIDTH:0]   m_q,  m_d;
    logic [WIDTH:0]   hq_q, hq_d;
    logic [WIDTH-1:0] lq_q, lq_d;
    logic             q1_q, q1_d;

    always_comb begin
        m_d  = m_q;
        hq_d = hq_q;
        lq_d = lq_q;
        q1_d = q1_q;
        if (i_load_a) begin
            m_d = {i_a[WIDTH-1], i_a};
        end
        if (i_load_b) begin
            lq_d = i_b;
            hq_d = '0;
            q1_d = 1'b0;
        end else if (i_load_add) begin
            hq_d = i_add_sub ? (hq_q - m_q) : (hq_q + m_q);
        end else if (i_shift_hq_lq_q_1) begin
            hq_d = {hq_q[WIDTH], hq_q[WIDTH:1]};
            lq_d = {hq_q[0], lq_q[WIDTH-1:1]};
            q1_d = lq_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q  <= '0;
            hq_q <= '0;
            lq_q <= '0;
            q1_q <= 1'b0;
        end else begin
            m_q  <= m_d;
            hq_q <= hq_d;
            lq_q <= lq_d;
            q1_q <= q1_d;
        end
    end

    assign o_q_lsb = {lq_q[0], q1_q};

    // Product as it will read after the pending shift: {HQ[W-1:0], LQ} of the
    // shifted register, so the final SHIFT cycle can load Y directly.
    assign o_product_next = {hq_q, lq_q[WIDTH-1:1]};

endmodule

`default_nettype wire

// File: rtl/booth_multiplier.sv
// ============================================================================
// Module      : booth_multiplier
// Description : Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH.
//               Optional macro BOOTH_ZERO_BYPASS_EN short-cuts zero operands.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] Y,
    output logic               done,
    output logic               busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0] y_q, y_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               load_a, load_b, load_add, add_sub, shift_en;
    logic [1:0]         q_lsb;
    logic [2*WIDTH-1:0] product_next;
    logic               zero_bypass;

`ifdef BOOTH_ZERO_BYPASS_EN
    assign zero_bypass = (A == '0) || (B == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    booth_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk               (clk),
        .rst               (rst),
        .i_load_a          (load_a),
        .i_load_b          (load_b),
        .i_load_add        (load_add),
        .i_add_sub         (add_sub),
        .i_shift_hq_lq_q_1 (shift_en),
        .i_a               (A),
        .i_b               (B),
        .o_q_lsb           (q_lsb),
        .o_product_next    (product_next)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        y_d      = y_q;
        done_d   = 1'b0;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_add = 1'b0;
        add_sub  = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && zero_bypass) begin
                    state_d = DONE;
                    y_d     = '0;
                    done_d  = 1'b1;
                end else if (start) begin
                    load_a  = 1'b1;
                    load_b  = 1'b1;
                    count_d = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                load_add = (q_lsb == ADD_M) || (q_lsb == SUB_M);
                add_sub  = (q_lsb == SUB_M);
                state_d  = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                count_d  = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    state_d = DONE;
                    y_d     = product_next;
                    done_d  = 1'b1;
                end else begin
                    state_d = ADD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign Y    = y_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_multiplier.sv
// ============================================================================
// Module      : tb_booth_multiplier
// Description : Scoreboard bench for booth_multiplier with a signed-product model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_multiplier;

    localparam int W = 8;
`ifdef BOOTH_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [2*W-1:0] y;
        int             cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   A, B;
    logic [2*W-1:0] Y;
    logic           done, busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    int   busy_from = 1;
    int   busy_until = 0;
    exp_t q[$];

    booth_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .done  (done),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = a * b;
        return p;
    endfunction

    // Monitor: per-cycle busy/Y-hold checks and scoreboard pop on done
    initial begin : monitor
        exp_t           e;
        logic [2*W-1:0] y_hold;
        y_hold = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_until));
                if (done === 1'b1) begin
                    if (q.size() == 0) begin
                        check("spurious_done", 64'(done), 64'd0);
                    end else begin
                        e = q.pop_front();
                        check("product", 64'(Y), 64'(e.y));
                        check("done_cycle", 64'(cyc), 64'(e.cyc));
                        y_hold = e.y;
                    end
                end else begin
                    check("y_hold", 64'(Y), 64'(y_hold));
                end
                if (rst) y_hold = '0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        exp_t e;
        lat = (BYPASS && (a == '0 || b == '0)) ? 1 : 2*W+1;
        A = a;
        B = b;
        start = 1'b1;
        e.y   = ref_mul(a, b);
        e.cyc = cyc + lat;
        q.push_back(e);
        busy_from  = cyc + 1;
        busy_until = cyc + lat;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
        int lat;
        issue(a, b, lat);
        repeat (lat + gap) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin : driver
        int lat;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_y", 64'(Y), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        mon_en = 1'b1;

        run_op(8'd3, 8'hFB, 3);
        check("hold_after_first", 64'(Y), 64'h0000_FFF1);
        run_op(8'h80, 8'h80, 0);
        run_op(8'h7F, 8'h80, 1);
        run_op(8'hFF, 8'hFF, 0);
        run_op(8'd0, 8'd55, 2);
        run_op(8'd55, 8'd0, 0);

        // start re-asserted with new operands while busy must be ignored
        issue(8'd2, 8'd2, lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        A = 8'd7; B = 8'd7; start = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end

        // reset mid-operation abandons the result
        issue(8'd5, 8'd6, lat);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        q.delete();
        busy_until = cyc;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_y", 64'(Y), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        repeat (20) begin
            @(posedge clk); #1;
        end
        run_op(8'd5, 8'd6, 1);

        for (int i = 0; i < 2000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 15))
                0: ra = '0;
                1: rb = '0;
                2: ra = 8'h80;
                3: rb = 8'h80;
                default: ;
            endcase
            run_op(ra, rb, $urandom_range(0, 1));
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pending_results", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
